// File: rtl/rvga_types.sv
// Shared rvga core types: register index, data word and the decode->execute payload.
package rvga_types;

  typedef logic [4:0]  rvga_reg;
  typedef logic [31:0] rvga_word;

  localparam rvga_reg RVGA_REG_ZERO = '0;

  // pc is carried in a full word; stages with a narrower PC_WIDTH use the low bits.
  typedef struct packed {
    rvga_word pc;
    rvga_reg  rs1;
    rvga_reg  rs2;
    logic     rs1_v;
    logic     rs2_v;
    rvga_reg  rd;
    logic     rd_w_v;
    logic     load;
    rvga_word rs1_data;
    rvga_word rs2_data;
  } de_pkt_s;

  function automatic de_pkt_s de_bubble(input de_pkt_s p);
    de_pkt_s b;
    b        = p;
    b.rs1_v  = 1'b0;
    b.rs2_v  = 1'b0;
    b.rd_w_v = 1'b0;
    b.load   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/decode_execute_stage_if.sv
// Decode/execute handshake and payload bundle around the decode->execute pipeline register.
interface decode_execute_stage_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  import rvga_types::*;

  logic                 decode_v_i;
  logic                 decode_ready_o;
  logic [PC_WIDTH-1:0]  decode_pc_i;
  rvga_reg              decode_rs1_i;
  rvga_reg              decode_rs2_i;
  logic                 decode_rs1_v_i;
  logic                 decode_rs2_v_i;
  rvga_reg              decode_rd_i;
  logic                 decode_rd_w_v_i;
  logic                 decode_load_i;
  rvga_word             decode_rs1_data_i;
  rvga_word             decode_rs2_data_i;

  logic                 execute_ready_i;
  logic                 flush_i;

  logic                 execute_v_o;
  logic [PC_WIDTH-1:0]  execute_pc_o;
  rvga_reg              execute_rs1_o;
  rvga_reg              execute_rs2_o;
  logic                 execute_rs1_v_o;
  logic                 execute_rs2_v_o;
  rvga_reg              execute_rd_o;
  logic                 execute_rd_w_v_o;
  logic                 execute_load_o;
  rvga_word             execute_rs1_data_o;
  rvga_word             execute_rs2_data_o;

  logic                 load_use_stall_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;
  logic [CNT_WIDTH-1:0] flush_cnt_o;

  modport master (
    output decode_v_i, decode_pc_i, decode_rs1_i, decode_rs2_i,
           decode_rs1_v_i, decode_rs2_v_i, decode_rd_i, decode_rd_w_v_i,
           decode_load_i, decode_rs1_data_i, decode_rs2_data_i,
           execute_ready_i, flush_i,
    input  decode_ready_o, execute_v_o, execute_pc_o, execute_rs1_o,
           execute_rs2_o, execute_rs1_v_o, execute_rs2_v_o, execute_rd_o,
           execute_rd_w_v_o, execute_load_o, execute_rs1_data_o,
           execute_rs2_data_o, load_use_stall_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  decode_v_i, decode_pc_i, decode_rs1_i, decode_rs2_i,
           decode_rs1_v_i, decode_rs2_v_i, decode_rd_i, decode_rd_w_v_i,
           decode_load_i, decode_rs1_data_i, decode_rs2_data_i,
           execute_ready_i, flush_i,
    output decode_ready_o, execute_v_o, execute_pc_o, execute_rs1_o,
           execute_rs2_o, execute_rs1_v_o, execute_rs2_v_o, execute_rd_o,
           execute_rd_w_v_o, execute_load_o, execute_rs1_data_o,
           execute_rs2_data_o, load_use_stall_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/decode_execute_stage_load_use_detect.sv
// Load-use hazard check of an incoming decode instruction against a held load.
module load_use_detect
  import rvga_types::*;
(
  input  logic    held_v,
  input  logic    held_load,
  input  logic    held_rd_w_v,
  input  rvga_reg held_rd,
  input  logic    decode_v,
  input  rvga_reg rs1,
  input  logic    rs1_v,
  input  rvga_reg rs2,
  input  logic    rs2_v,
  output logic    load_use
);

  logic held_writes;
  logic src_match;

  // x0 is hard-wired, so a load targeting it can never feed a dependent instruction.
  assign held_writes = held_v & held_load & held_rd_w_v & (held_rd != RVGA_REG_ZERO);
  assign src_match   = (rs1_v & (rs1 == held_rd)) | (rs2_v & (rs2 == held_rd));
  assign load_use    = held_writes & decode_v & src_match;

endmodule

// File: rtl/decode_execute_stage.sv
// Decode->execute pipeline register with load-use bubble insertion, flush kill and perf counters.
module decode_execute_stage
  import rvga_types::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  decode_execute_stage_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  de_pkt_s              held_q;
  de_pkt_s              held_d;
  de_pkt_s              incoming;
  logic                 valid_q;
  logic                 valid_d;
  logic                 adv;
  logic                 load_use;
  logic                 stall;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  load_use_detect u_load_use_detect (
    .held_v      (valid_q),
    .held_load   (held_q.load),
    .held_rd_w_v (held_q.rd_w_v),
    .held_rd     (held_q.rd),
    .decode_v    (bus.decode_v_i),
    .rs1         (bus.decode_rs1_i),
    .rs1_v       (bus.decode_rs1_v_i),
    .rs2         (bus.decode_rs2_i),
    .rs2_v       (bus.decode_rs2_v_i),
    .load_use    (load_use)
  );

  assign adv   = bus.execute_ready_i | ~valid_q;
  assign stall = load_use & ~bus.flush_i;

  always_comb begin
    incoming          = '0;
    incoming.pc       = rvga_word'(bus.decode_pc_i);
    incoming.rs1      = bus.decode_rs1_i;
    incoming.rs2      = bus.decode_rs2_i;
    incoming.rs1_v    = bus.decode_rs1_v_i;
    incoming.rs2_v    = bus.decode_rs2_v_i;
    incoming.rd       = bus.decode_rd_i;
    incoming.rd_w_v   = bus.decode_rd_w_v_i;
    incoming.load     = bus.decode_load_i;
    incoming.rs1_data = bus.decode_rs1_data_i;
    incoming.rs2_data = bus.decode_rs2_data_i;
  end

  // Flush beats everything; a bubble keeps data fields so only control bits toggle.
  always_comb begin
    held_d  = held_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
      held_d  = de_bubble(held_q);
    end else if (adv && bus.decode_v_i && !load_use) begin
      valid_d = 1'b1;
      held_d  = incoming;
    end else if (adv) begin
      valid_d = 1'b0;
      held_d  = de_bubble(held_q);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      held_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      held_q  <= held_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (bus.flush_i && valid_q && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.decode_ready_o     = bus.flush_i | (adv & ~load_use);
  assign bus.load_use_stall_o   = stall;
  assign bus.execute_v_o        = valid_q;
  assign bus.execute_pc_o       = held_q.pc[PC_WIDTH-1:0];
  assign bus.execute_rs1_o      = held_q.rs1;
  assign bus.execute_rs2_o      = held_q.rs2;
  assign bus.execute_rs1_v_o    = held_q.rs1_v;
  assign bus.execute_rs2_v_o    = held_q.rs2_v;
  assign bus.execute_rd_o       = held_q.rd;
  assign bus.execute_rd_w_v_o   = held_q.rd_w_v;
  assign bus.execute_load_o     = held_q.load;
  assign bus.execute_rs1_data_o = held_q.rs1_data;
  assign bus.execute_rs2_data_o = held_q.rs2_data;
  assign bus.stall_cnt_o        = stall_cnt_q;
  assign bus.flush_cnt_o        = flush_cnt_q;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage; counters built 2 bits wide to reach saturation quickly.
module tb_decode_execute_stage;
  import rvga_types::*;

  logic clk_i;
  logic reset_n_i;
  int   passed;
  int   total;
  de_pkt_s exp_q[$];

  decode_execute_stage_if #(.PC_WIDTH(32), .CNT_WIDTH(2)) bus ();

  decode_execute_stage #(.PC_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic de_pkt_s mk(input logic [31:0] pc, input rvga_reg rs1, input logic rs1_v,
                                 input rvga_reg rs2, input logic rs2_v, input rvga_reg rd,
                                 input logic rd_w_v, input logic load);
    de_pkt_s p;
    p.pc       = pc;
    p.rs1      = rs1;
    p.rs2      = rs2;
    p.rs1_v    = rs1_v;
    p.rs2_v    = rs2_v;
    p.rd       = rd;
    p.rd_w_v   = rd_w_v;
    p.load     = load;
    p.rs1_data = $urandom;
    p.rs2_data = $urandom;
    return p;
  endfunction

  function automatic de_pkt_s cur_pkt();
    de_pkt_s p;
    p.pc       = bus.execute_pc_o;
    p.rs1      = bus.execute_rs1_o;
    p.rs2      = bus.execute_rs2_o;
    p.rs1_v    = bus.execute_rs1_v_o;
    p.rs2_v    = bus.execute_rs2_v_o;
    p.rd       = bus.execute_rd_o;
    p.rd_w_v   = bus.execute_rd_w_v_o;
    p.load     = bus.execute_load_o;
    p.rs1_data = bus.execute_rs1_data_o;
    p.rs2_data = bus.execute_rs2_data_o;
    return p;
  endfunction

  task automatic drive(input de_pkt_s p);
    bus.decode_v_i        = 1'b1;
    bus.decode_pc_i       = p.pc;
    bus.decode_rs1_i      = p.rs1;
    bus.decode_rs2_i      = p.rs2;
    bus.decode_rs1_v_i    = p.rs1_v;
    bus.decode_rs2_v_i    = p.rs2_v;
    bus.decode_rd_i       = p.rd;
    bus.decode_rd_w_v_i   = p.rd_w_v;
    bus.decode_load_i     = p.load;
    bus.decode_rs1_data_i = p.rs1_data;
    bus.decode_rs2_data_i = p.rs2_data;
  endtask

  // Executes one clock; whatever execute consumes or loses to flush leaves the scoreboard here.
  task automatic tick();
    de_pkt_s exp_p;
    de_pkt_s act_p;
    if (bus.execute_v_o === 1'b1 && bus.flush_i === 1'b1) begin
      if (exp_q.size() > 0) exp_q.pop_front();
    end else if (bus.execute_v_o === 1'b1 && bus.execute_ready_i === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_underflow: got pc %0h expected no instruction", bus.execute_pc_o);
      end else begin
        exp_p = exp_q.pop_front();
        act_p = cur_pkt();
        if (act_p !== exp_p) $display("[TB] FAIL sb_pkt: got %0h expected %0h", act_p, exp_p);
        else passed++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    bus.decode_v_i        = 1'b0;
    bus.decode_pc_i       = '0;
    bus.decode_rs1_i      = '0;
    bus.decode_rs2_i      = '0;
    bus.decode_rs1_v_i    = 1'b0;
    bus.decode_rs2_v_i    = 1'b0;
    bus.decode_rd_i       = '0;
    bus.decode_rd_w_v_i   = 1'b0;
    bus.decode_load_i     = 1'b0;
    bus.decode_rs1_data_i = '0;
    bus.decode_rs2_data_i = '0;
    bus.execute_ready_i   = 1'b1;
    bus.flush_i           = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    #1;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
    total++;
    if (exp_q.size() != 0) $display("[TB] FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    de_pkt_s p;
    idle_inputs();
    p = mk(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    drive(p);
    repeat (2) @(negedge clk_i);
    total++;
    if ({bus.execute_v_o, bus.execute_pc_o, bus.stall_cnt_o, bus.flush_cnt_o} !== '0)
      $display("[TB] FAIL reset_outputs: got v=%0b pc=%0h expected all zero", bus.execute_v_o, bus.execute_pc_o);
    else passed++;
    reset_n_i = 1'b1;
    #1;
    total++;
    if (bus.decode_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %0b expected 1", bus.decode_ready_o);
    else passed++;
    exp_q.push_back(p);
    tick();
    total++;
    if (bus.execute_v_o !== 1'b1 || bus.execute_pc_o !== 32'h100)
      $display("[TB] FAIL reset_first: got v=%0b pc=%0h expected v=1 pc=100", bus.execute_v_o, bus.execute_pc_o);
    else passed++;
    bus.decode_v_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    total++;
    if (bus.execute_v_o !== 1'b0 || bus.execute_pc_o !== 32'h0)
      $display("[TB] FAIL reset_async: got v=%0b pc=%0h expected v=0 pc=0", bus.execute_v_o, bus.execute_pc_o);
    else passed++;
    exp_q.delete();
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_load_use();
    de_pkt_s ld;
    de_pkt_s add;
    apply_reset();
    ld  = mk(32'h10, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    add = mk(32'h14, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    drive(ld);
    exp_q.push_back(ld);
    #1 tick();
    drive(add);
    #1;
    total++;
    if (bus.load_use_stall_o !== 1'b1 || bus.decode_ready_o !== 1'b0)
      $display("[TB] FAIL lu_detect: got stall=%0b ready=%0b expected stall=1 ready=0", bus.load_use_stall_o, bus.decode_ready_o);
    else passed++;
    tick();
    total++;
    if ({bus.execute_v_o, bus.execute_rs1_v_o, bus.execute_rs2_v_o, bus.execute_rd_w_v_o, bus.execute_load_o} !== 5'b0)
      $display("[TB] FAIL lu_bubble: got v=%0b load=%0b expected all control 0", bus.execute_v_o, bus.execute_load_o);
    else passed++;
    total++;
    if (bus.execute_pc_o !== 32'h10) $display("[TB] FAIL lu_bubble_pc: got %0h expected 10", bus.execute_pc_o);
    else passed++;
    #1;
    total++;
    if (bus.load_use_stall_o !== 1'b0 || bus.decode_ready_o !== 1'b1)
      $display("[TB] FAIL lu_release: got stall=%0b ready=%0b expected stall=0 ready=1", bus.load_use_stall_o, bus.decode_ready_o);
    else passed++;
    exp_q.push_back(add);
    tick();
    total++;
    if (bus.execute_pc_o !== 32'h14 || bus.stall_cnt_o !== 2'd1)
      $display("[TB] FAIL lu_enter: got pc=%0h cnt=%0d expected pc=14 cnt=1", bus.execute_pc_o, bus.stall_cnt_o);
    else passed++;
    drain();
  endtask

  task automatic test_no_hazard();
    de_pkt_s seq[6];
    apply_reset();
    seq[0] = mk(32'h20, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    seq[1] = mk(32'h24, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    seq[2] = mk(32'h28, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    seq[3] = mk(32'h2c, 5'd3, 1'b1, 5'd5, 1'b0, 5'd8, 1'b1, 1'b0);
    seq[4] = mk(32'h30, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    seq[5] = mk(32'h34, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      #1;
      total++;
      if (bus.load_use_stall_o !== 1'b0 || bus.decode_ready_o !== 1'b1)
        $display("[TB] FAIL nohaz_%0d: got stall=%0b ready=%0b expected stall=0 ready=1", i, bus.load_use_stall_o, bus.decode_ready_o);
      else passed++;
      exp_q.push_back(seq[i]);
      tick();
    end
    drive(seq[5]);
    #1;
    total++;
    if (bus.load_use_stall_o !== 1'b1) $display("[TB] FAIL rs2_hazard: got %0b expected 1", bus.load_use_stall_o);
    else passed++;
    tick();
    exp_q.push_back(seq[5]);
    #1 tick();
    total++;
    if (bus.stall_cnt_o !== 2'd1) $display("[TB] FAIL nohaz_cnt: got %0d expected 1", bus.stall_cnt_o);
    else passed++;
    drain();
  endtask

  task automatic test_flush();
    de_pkt_s a;
    apply_reset();
    a = mk(32'h200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    drive(a);
    exp_q.push_back(a);
    #1 tick();
    drive(mk(32'h204, 5'd1, 1'b1, 5'd2, 1'b0, 5'd4, 1'b1, 1'b0));
    bus.flush_i = 1'b1;
    #1;
    total++;
    if (bus.decode_ready_o !== 1'b1) $display("[TB] FAIL flush_ready: got %0b expected 1", bus.decode_ready_o);
    else passed++;
    tick();
    total++;
    if (bus.execute_v_o !== 1'b0 || bus.flush_cnt_o !== 2'd1 || bus.execute_load_o !== 1'b0)
      $display("[TB] FAIL flush_kill: got v=%0b cnt=%0d expected v=0 cnt=1", bus.execute_v_o, bus.flush_cnt_o);
    else passed++;
    #1 tick();
    total++;
    if (bus.execute_v_o !== 1'b0 || bus.flush_cnt_o !== 2'd1)
      $display("[TB] FAIL flush_empty: got v=%0b cnt=%0d expected v=0 cnt=1", bus.execute_v_o, bus.flush_cnt_o);
    else passed++;
    bus.flush_i = 1'b0;
    a = mk(32'h210, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    drive(a);
    exp_q.push_back(a);
    #1 tick();
    drive(mk(32'h214, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0));
    bus.flush_i = 1'b1;
    #1;
    total++;
    if (bus.load_use_stall_o !== 1'b0 || bus.decode_ready_o !== 1'b1)
      $display("[TB] FAIL flush_vs_lu: got stall=%0b ready=%0b expected stall=0 ready=1", bus.load_use_stall_o, bus.decode_ready_o);
    else passed++;
    tick();
    total++;
    if (bus.stall_cnt_o !== 2'd0 || bus.flush_cnt_o !== 2'd2)
      $display("[TB] FAIL flush_cnts: got stall=%0d flush=%0d expected stall=0 flush=2", bus.stall_cnt_o, bus.flush_cnt_o);
    else passed++;
    drain();
  endtask

  task automatic test_backpressure();
    de_pkt_s p;
    de_pkt_s q;
    apply_reset();
    p = mk(32'h300, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    q = mk(32'h304, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    drive(p);
    exp_q.push_back(p);
    #1 tick();
    drive(q);
    bus.execute_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.decode_ready_o !== 1'b0) $display("[TB] FAIL bp_ready_%0d: got %0b expected 0", i, bus.decode_ready_o);
      else passed++;
      tick();
      total++;
      if (cur_pkt() !== p || bus.execute_v_o !== 1'b1)
        $display("[TB] FAIL bp_hold_%0d: got pc=%0h v=%0b expected pc=300 v=1", i, bus.execute_pc_o, bus.execute_v_o);
      else passed++;
    end
    bus.execute_ready_i = 1'b1;
    #1;
    total++;
    if (bus.decode_ready_o !== 1'b1) $display("[TB] FAIL bp_release: got %0b expected 1", bus.decode_ready_o);
    else passed++;
    exp_q.push_back(q);
    tick();
    total++;
    if (bus.execute_pc_o !== 32'h304) $display("[TB] FAIL bp_load: got %0h expected 304", bus.execute_pc_o);
    else passed++;
    drain();
  endtask

  task automatic test_saturation();
    de_pkt_s ld;
    de_pkt_s dep;
    apply_reset();
    ld  = mk(32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    dep = mk(32'h404, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    drive(ld);
    exp_q.push_back(ld);
    #1 tick();
    drive(dep);
    bus.execute_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1 tick();
      total++;
      if (bus.stall_cnt_o !== 2'((i < 3) ? i : 3) || bus.execute_pc_o !== 32'h400 || bus.execute_v_o !== 1'b1)
        $display("[TB] FAIL sat_%0d: got cnt=%0d pc=%0h expected cnt=%0d pc=400", i, bus.stall_cnt_o, bus.execute_pc_o, (i < 3) ? i : 3);
      else passed++;
    end
    bus.execute_ready_i = 1'b1;
    #1;
    total++;
    if (bus.load_use_stall_o !== 1'b1) $display("[TB] FAIL sat_stall: got %0b expected 1", bus.load_use_stall_o);
    else passed++;
    tick();
    total++;
    if (bus.stall_cnt_o !== 2'd3 || bus.execute_v_o !== 1'b0)
      $display("[TB] FAIL sat_hold: got cnt=%0d v=%0b expected cnt=3 v=0", bus.stall_cnt_o, bus.execute_v_o);
    else passed++;
    exp_q.push_back(dep);
    #1 tick();
    drain();
  endtask

  task automatic test_back_to_back();
    de_pkt_s p;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      p = mk(32'h500 + 32'(4 * i), 5'(i + 1), 1'b1, 5'(i + 10), 1'b1, 5'(i + 20), 1'b1, 1'b0);
      drive(p);
      #1;
      total++;
      if (bus.decode_ready_o !== 1'b1) $display("[TB] FAIL b2b_ready_%0d: got %0b expected 1", i, bus.decode_ready_o);
      else passed++;
      exp_q.push_back(p);
      tick();
    end
    drain();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    clk_i     = 1'b0;
    reset_n_i = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_execute_stage.md
Name: decode_execute_stage

Overview:
- Pipeline register between decode and execute in the rvga 5-stage core.
- Produces the execute-stage rs1/rs2/rd indices, valid qualifiers and operands consumed by the operand-forwarding logic.
- Detects load-use hazards against the instruction it holds, stalls decode one cycle and inserts a bubble.
- Kills its contents on flush and keeps saturating stall/flush counters.

Parameters:
- PC_WIDTH, 32, width of pc field
- CNT_WIDTH, 16, width of each performance counter (saturating)

Ports:
- clk_i  in  1  clock, all state rising-edge
- reset_n_i  in  1  asynchronous active-low reset
- decode_v_i  in  1  decode presents a valid instruction
- decode_ready_o  out  1  stage accepts decode payload this cycle
- decode_pc_i  in  PC_WIDTH  instruction pc
- decode_rs1_i, decode_rs2_i  in  5 each (rvga_reg)  source indices
- decode_rs1_v_i, decode_rs2_v_i  in  1 each  source actually read
- decode_rd_i  in  5 (rvga_reg)  destination index
- decode_rd_w_v_i  in  1  instruction writes rd
- decode_load_i  in  1  instruction is a load
- decode_rs1_data_i, decode_rs2_data_i  in  32 each (rvga_word)  register-file operands
- execute_ready_i  in  1  execute can take a new instruction (low while multi-cycle op busy)
- flush_i  in  1  redirect from execute: kill held and incoming instruction
- execute_v_o  out  1  register holds a valid instruction
- execute_pc_o  out  PC_WIDTH
- execute_rs1_o, execute_rs2_o  out  5 each
- execute_rs1_v_o, execute_rs2_v_o  out  1 each
- execute_rd_o  out  5
- execute_rd_w_v_o  out  1
- execute_load_o  out  1
- execute_rs1_data_o, execute_rs2_data_o  out  32 each
- load_use_stall_o  out  1  combinational: hazard detected this cycle
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH each

Behaviour:
- Reset (async, reset_n_i low): every registered output and both counters go to 0. Applies mid-stall or mid-flush; the first cycle after release behaves as empty stage.
- adv = execute_ready_i | ~execute_v_o.
- load_use = execute_v_o & execute_load_o & execute_rd_w_v_o & (execute_rd_o != 0) & decode_v_i & ((decode_rs1_v_i & decode_rs1_i == execute_rd_o) | (decode_rs2_v_i & decode_rs2_i == execute_rd_o)).
- load_use_stall_o = load_use & ~flush_i.
- decode_ready_o = flush_i | (adv & ~load_use). Upstream drains during flush; the accepted payload is dropped.
- Next state, priority order:
  - flush_i: execute_v_o <= 0 and all control fields (rs*_v, rd_w_v, load) <= 0.
  - else if adv & decode_v_i & ~load_use: load the full payload, execute_v_o <= 1.
  - else if adv: bubble. execute_v_o <= 0, control fields <= 0, data/pc/index fields hold.
  - else (execute busy, holding valid instruction): hold everything.
- Invariant: execute_v_o = 0 implies execute_rs1_v_o = execute_rs2_v_o = execute_rd_w_v_o = execute_load_o = 0.
- Latency: one cycle decode→execute. A load-use hazard costs exactly one bubble; the load then sits in memory and the dependent instruction enters execute the following cycle.
- A load-use hazard while execute is busy (adv = 0): stall_cnt still counts; the state holds.
- Register 0 never causes a hazard.
- stall_cnt_o: +1 each cycle load_use_stall_o = 1; saturates at all-ones, no wrap.
- flush_cnt_o: +1 on each flush_i cycle with execute_v_o = 1 (a real kill); saturates.
- Simultaneous flush_i and load_use: flush wins, no stall counted.

Decomposition:
- rvga_types (shared package) receives:
  - rvga_reg (5b) and rvga_word (32b), existing
  - new struct de_pkt_s {pc, rs1, rs2, rs1_v, rs2_v, rd, rd_w_v, load, rs1_data, rs2_data}
  - constant RVGA_REG_ZERO = 0
- Sub-module load_use_detect: combinational, inputs are held rd/load/valid plus decode rs indices/valids, output is load_use. It is reused later by the decode-stage scoreboard.

Test Plan:
- Reset: reset_n_i low, then released with decode_v_i = 1, pc = 0x100 → outputs 0 during reset; cycle after release execute_v_o = 1, execute_pc_o = 0x100, decode_ready_o = 1.
- Load-use: hold load rd = x5; decode presents add rs1 = x5 (rs1_v = 1) → load_use_stall_o = 1, decode_ready_o = 0. Next cycle execute_v_o = 0, all control outputs 0. Following cycle add enters, stall_cnt_o = 1.
- Register-zero and no-read cases: load rd = x0 with dependent rs1 = x0, or rs2 = x5 with rs2_v = 0 → no stall, back-to-back issue.
- Flush: flush_i = 1 while holding valid pc = 0x200 and decode_v_i = 1 → decode_ready_o = 1, next cycle execute_v_o = 0, flush_cnt_o = 1. Flush with empty stage leaves flush_cnt_o unchanged.
- Backpressure: execute_ready_i = 0 for 3 cycles, decode_v_i = 1 → all outputs stable, decode_ready_o = 0. On release the new payload loads in one cycle.
- Saturation: CNT_WIDTH = 2, 5 consecutive stall cycles → stall_cnt_o = 3, then stays 3.
